// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures the memory word into IF/ID.
// Ports: clock/reset, stall/branch controls, memory word/end flag in; PC, IF/ID and status out.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic [31:0] instruction,
  input  logic        fimDoArquivo,
  output logic [31:0] readAddress,
  output logic [31:0] ifidPC,
  output logic [31:0] ifidInstruction,
  output logic        ifidValid,
  output logic        halted,
  output logic [31:0] fetchCount
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        endSeen;

  assign readAddress = pc;
  assign endSeen     = fimDoArquivo | (instruction == 32'h0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= RUN;
      pc              <= RESET_PC;
      ifidPC          <= 32'h0;
      ifidInstruction <= NOP;
      ifidValid       <= 1'b0;
      halted          <= 1'b0;
      fetchCount      <= 32'h0;
    end else if (branchTaken) begin
      // Redirect wins over stall and also leaves HALT.
      state           <= RUN;
      halted          <= 1'b0;
      pc              <= {branchTarget[31:2], 2'b00};
      ifidPC          <= 32'h0;
      ifidInstruction <= NOP;
      ifidValid       <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!stall) begin
            if (endSeen) begin
              // PC stays on the end marker; bubble into decode.
              state           <= HALT;
              halted          <= 1'b1;
              ifidPC          <= 32'h0;
              ifidInstruction <= NOP;
              ifidValid       <= 1'b0;
            end else begin
              ifidPC          <= pc;
              ifidInstruction <= instruction;
              ifidValid       <= 1'b1;
              pc              <= pc + 32'd4;
              fetchCount      <= fetchCount + 32'd1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: reference model pushes expected
// post-edge state; a monitor pops and compares after every clock edge.
module tb_instruction_fetch;

  localparam logic [31:0] NOPW = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] instruction;
  logic        fimDoArquivo;
  logic [31:0] readAddress;
  logic [31:0] ifidPC;
  logic [31:0] ifidInstruction;
  logic        ifidValid;
  logic        halted;
  logic [31:0] fetchCount;

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .branchTaken    (branchTaken),
    .branchTarget   (branchTarget),
    .instruction    (instruction),
    .fimDoArquivo   (fimDoArquivo),
    .readAddress    (readAddress),
    .ifidPC         (ifidPC),
    .ifidInstruction(ifidInstruction),
    .ifidValid      (ifidValid),
    .halted         (halted),
    .fetchCount     (fetchCount)
  );

  always #5 clock = ~clock;

  // 64-word memory, aliased across the whole address space.
  logic [31:0] mem [64];
  logic        endFlag [64];

  always_comb begin
    instruction  = mem[readAddress[7:2]];
    fimDoArquivo = endFlag[readAddress[7:2]];
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifPc;
    logic [31:0] ifIns;
    logic        ifValid;
    logic        halt;
    logic [31:0] count;
  } exp_t;

  exp_t expQ[$];
  int   nVec  = 0;
  int   nFail = 0;

  // Reference model state.
  logic [31:0] mPc;
  logic [31:0] mIfPc;
  logic [31:0] mIfIns;
  logic        mIfValid;
  logic        mHalt;
  logic [31:0] mCount;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic br,
                           input logic [31:0] tgt, input logic st);
    logic [31:0] w;
    logic        e;
    w = mem[mPc[7:2]];
    e = endFlag[mPc[7:2]];
    if (rst) begin
      mPc = 0; mIfPc = 0; mIfIns = NOPW;
      mIfValid = 0; mHalt = 0; mCount = 0;
    end else if (br) begin
      mPc = tgt & ~32'd3;
      mIfPc = 0; mIfIns = NOPW; mIfValid = 0; mHalt = 0;
    end else if (mHalt || st) begin
      // everything held
    end else if (e || w == 0) begin
      mIfPc = 0; mIfIns = NOPW; mIfValid = 0; mHalt = 1;
    end else begin
      mIfPc = mPc; mIfIns = w; mIfValid = 1;
      mPc = mPc + 4; mCount = mCount + 1;
    end
  endtask

  // Drive one edge's inputs, record expectation, return at edge+1.
  task automatic cyc(input logic rst, input logic br,
                     input logic [31:0] tgt, input logic st);
    exp_t x;
    reset = rst; branchTaken = br; branchTarget = tgt; stall = st;
    modelStep(rst, br, tgt, st);
    x.pc = mPc; x.ifPc = mIfPc; x.ifIns = mIfIns;
    x.ifValid = mIfValid; x.halt = mHalt; x.count = mCount;
    expQ.push_back(x);
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are settled 3 time units after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #3;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        check("readAddress", readAddress, x.pc);
        check("ifidPC", ifidPC, x.ifPc);
        check("ifidInstruction", ifidInstruction, x.ifIns);
        check("ifidValid", {31'b0, ifidValid}, {31'b0, x.ifValid});
        check("halted", {31'b0, halted}, {31'b0, x.halt});
        check("fetchCount", fetchCount, x.count);
      end
    end
  end

  initial begin
    logic [31:0] a0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      endFlag[i] = 1'b0;
    end
    mem[0] = 32'hAAAA0001;
    mem[1] = 32'hBBBB0002;
    mem[2] = 32'hCCCC0003;
    endFlag[3] = 1'b1;
    mPc = 0; mIfPc = 0; mIfIns = NOPW; mIfValid = 0; mHalt = 0; mCount = 0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("resetIfValid", {31'b0, ifidValid}, 32'd0);
    check("resetIfIns", ifidInstruction, NOPW);
    // Sequential fetch with a 3-cycle stall on B.
    cyc(0, 0, 0, 0);
    check("fetchA", ifidInstruction, 32'hAAAA0001);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("stallHoldB", ifidInstruction, 32'hBBBB0002);
    check("stallHoldPC", ifidPC, 32'd4);
    cyc(0, 0, 0, 0);
    check("fetchC", ifidInstruction, 32'hCCCC0003);
    check("count3", fetchCount, 32'd3);
    // End marker at 12.
    cyc(0, 0, 0, 0);
    check("haltSet", {31'b0, halted}, 32'd1);
    check("haltPc", readAddress, 32'd12);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // Resume at 4.
    cyc(0, 1, 32'd4, 0);
    check("resumeHalted", {31'b0, halted}, 32'd0);
    check("resumePc", readAddress, 32'd4);
    cyc(0, 0, 0, 0);
    check("resumeB", ifidInstruction, 32'hBBBB0002);
    // Branch together with stall to 0x22.
    cyc(0, 1, 32'h22, 1);
    check("brPc", readAddress, 32'h20);
    check("brBubble", ifidInstruction, NOPW);
    cyc(0, 0, 0, 0);
    check("brTarget", ifidInstruction, mem[8]);
    // Reset mid-run at 0x40.
    cyc(0, 1, 32'h40, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("midResetPc", readAddress, 32'd0);
    check("midResetCount", fetchCount, 32'd0);
    // PC wrap.
    cyc(0, 1, 32'hFFFFFFFE, 0);
    cyc(0, 0, 0, 0);
    check("wrapPc", readAddress, 32'd0);
    cyc(0, 0, 0, 0);

    // Random phase with fresh memory contents.
    for (int i = 0; i < 64; i++) begin
      mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : $urandom | 32'h1;
      endFlag[i] = ($urandom_range(0, 15) == 0);
    end
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      a0 = $urandom;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
          a0, $urandom_range(0, 3) == 0);
    end
    reset = 0; branchTaken = 0; stall = 0;
    repeat (3) @(posedge clock);
    #4;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL scoreboardDrain: got %0d pending want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
